// File: rtl/cc_frame_loader.sv
// Serial BCD digit loader: assembles four-digit frames with an opcode, drops frames
// containing an illegal digit, and presents them through a valid/ready holding register.
module cc_frame_loader #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_digit,
  input  logic [1:0]       in_opt,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       frm_n0,
  output logic [3:0]       frm_n1,
  output logic [3:0]       frm_n2,
  output logic [3:0]       frm_n3,
  output logic [1:0]       frm_opt,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {S_COLL, S_DROP, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      pos_q, pos_d;
  logic [3:0][3:0] asm_q;
  logic [1:0]      asm_opt_q;
  logic [3:0][3:0] hold_q;
  logic [1:0]      hold_opt_q;
  logic            out_valid_q, err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  logic beat, fire, good, store, lat_opt, load_coll, load_wait;

  assign in_ready = (state_q != S_WAIT);
  assign beat     = in_valid && in_ready;
  assign fire     = out_valid_q && out_ready;
  assign good     = (in_digit <= 4'd9);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    err_d     = 1'b0;
    store     = 1'b0;
    lat_opt   = 1'b0;
    load_coll = 1'b0;
    load_wait = 1'b0;
    case (state_q)
      S_COLL: if (beat) begin
        lat_opt = (pos_q == 2'd0);
        pos_d   = pos_q + 2'd1;
        if (good) begin
          store = 1'b1;
          if (pos_q == 2'd3) begin
            // Holding register free now or freed by this edge's handoff
            if (!out_valid_q || out_ready) load_coll = 1'b1;
            else                           state_d   = S_WAIT;
          end
        end else begin
          err_d = 1'b1;
          if (pos_q != 2'd3) state_d = S_DROP;
        end
      end
      S_DROP: if (beat) begin
        pos_d = pos_q + 2'd1;
        if (pos_q == 2'd3) state_d = S_COLL;
      end
      S_WAIT: if (out_ready) begin
        load_wait = 1'b1;
        pos_d     = 2'd0;
        state_d   = S_COLL;
      end
      default: begin
        state_d = S_COLL;
        pos_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COLL;
      pos_q     <= 2'd0;
      err_q     <= 1'b0;
      asm_q     <= '0;
      asm_opt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      if (store)   asm_q[pos_q] <= in_digit;
      if (lat_opt) asm_opt_q    <= in_opt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_opt_q  <= 2'd0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // The 4th digit bypasses the assembly register on a direct load
      if (load_coll) begin
        hold_q     <= {in_digit, asm_q[2:0]};
        hold_opt_q <= asm_opt_q;
      end else if (load_wait) begin
        hold_q     <= asm_q;
        hold_opt_q <= asm_opt_q;
      end
      if (load_coll || load_wait) out_valid_q <= 1'b1;
      else if (fire)              out_valid_q <= 1'b0;
      if (fire) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign frm_n0    = hold_q[0];
  assign frm_n1    = hold_q[1];
  assign frm_n2    = hold_q[2];
  assign frm_n3    = hold_q[3];
  assign frm_opt   = hold_opt_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

endmodule
